lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DATA_LEN, default `ISA_WIDTH (64), data/address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  input  1  execute stage presents a memory op.
REQ-005 in_ready  output  1  LSU can accept an op this cycle.
REQ-006 addr  input  64  effective address (ALU add result).
REQ-007 wdata  input  64  store data (rs2), low bytes significant.
REQ-008 lsu_funct  input  4  LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6, SB=8, SH=9, SW=10, SD=11; others illegal.
REQ-009 mem_req_valid  output  1  memory request valid.
REQ-010 mem_req_ready  input  1  memory accepts request.
REQ-011 mem_addr  output  64  addr with bits [2:0] forced to 0.
REQ-012 mem_wen  output  1  1=store, 0=load.
REQ-013 mem_wdata  output  64  store data shifted to byte lane addr[2:0].
REQ-014 mem_wmask  output  8  byte enables, shifted by addr[2:0]; 0 for loads.
REQ-015 mem_rsp_valid  input  1  memory response (load data or store ack).
REQ-016 mem_rsp_data  input  64  aligned 8-byte read data.
REQ-017 out_valid  output  1  result available to writeback.
REQ-018 out_ready  input  1  writeback accepts result.
REQ-019 rdata  output  64  extracted, sign/zero-extended load data; 0 for stores and errors.
REQ-020 err  output  1  misaligned or illegal op; qualified by out_valid.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; exactly one active.
REQ-022 IDLE: in_ready=1; on in_valid, latch addr, wdata, lsu_funct.
REQ-023 IDLE accept, legal and aligned -> REQ; misaligned (H: addr[0]!=0, W: addr[1:0]!=0, D: addr[2:0]!=0) or illegal funct -> DONE with err=1, no memory request issued.
REQ-024 REQ: mem_req_valid=1, request fields stable until mem_req_ready; on mem_req_ready -> WAIT.
REQ-025 WAIT: mem_rsp_valid sampled only here; on it, capture extracted rdata (loads) -> DONE.
REQ-026 DONE: out_valid=1, rdata/err held stable until out_ready; on out_ready -> IDLE.
REQ-027 in_ready=0 in REQ, WAIT, DONE; no new op accepted before DONE handshake completes (no same-cycle DONE->accept).
REQ-028 Load extraction: byte/half/word selected by addr[2:0] from mem_rsp_data; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD passes through.
REQ-029 Store masks: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF, each shifted left by addr[2:0]; mem_wdata = wdata << (8*addr[2:0]).
REQ-030 Minimum latency: accept cycle N, request cycle N+1 (ready=1), response N+2, out_valid N+3.
REQ-031 mem_rsp_valid in IDLE, REQ or DONE is ignored.
REQ-032 All outputs registered or decoded from state and latched fields only; no combinational path from in_* to mem_*.

Reset
REQ-033 rst low -> state IDLE immediately; in_ready=1, mem_req_valid=0, out_valid=0, err=0, rdata=0, latched fields 0.
REQ-034 Reset mid-transaction abandons the op; no later response produces out_valid.

Structure
REQ-035 lsu_funct codes and LSU_FUNCT_WIDTH defined in shared header inst.vh; widths from config.vh.
REQ-036 One combinational sub-module lsu_load_align (data, offset, funct -> extended result), also reusable for difftest.

Verification
REQ-037 LW addr=0x8000_0004, mem_rsp_data=0x8765_4321_0000_0000 -> rdata=0xFFFF_FFFF_8765_4321, err=0, out_valid at N+3.
REQ-038 SB addr=0x8000_0003, wdata=0xAB -> mem_addr=0x8000_0000, mem_wmask=0x08, mem_wdata byte3=0xAB, mem_wen=1.
REQ-039 LH addr=0x8000_0001 -> err=1, rdata=0, mem_req_valid never asserted, out_valid at N+1.
REQ-040 mem_req_ready low 3 cycles then high, out_ready low 2 cycles -> request and rdata held stable, in_ready=0 throughout.
REQ-041 rst asserted in WAIT, then mem_rsp_valid pulse -> no out_valid, state IDLE, in_ready=1.
REQ-042 Back-to-back LBU addr=0x7 (rsp byte7=0x80 -> 0x80) then LB same -> 0xFFFF_FFFF_FFFF_FF80.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: widths, funct encodings, FSM states and alignment helpers.
package lsu_pkg;

  localparam int ISA_WIDTH       = 64;
  localparam int LSU_FUNCT_WIDTH = 4;

  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LB  = 4'd0;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LH  = 4'd1;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LW  = 4'd2;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LD  = 4'd3;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LBU = 4'd4;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LHU = 4'd5;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_LWU = 4'd6;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_SB  = 4'd8;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_SH  = 4'd9;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_SW  = 4'd10;
  localparam logic [LSU_FUNCT_WIDTH-1:0] LSU_SD  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic logic lsu_funct_legal(input logic [LSU_FUNCT_WIDTH-1:0] f);
    return (f != 4'd7) && (f <= LSU_SD);
  endfunction

  // funct[1:0] encodes access size (B/H/W/D) for both loads and stores.
  function automatic logic lsu_misaligned(input logic [LSU_FUNCT_WIDTH-1:0] f,
                                          input logic [2:0] off);
    case (f[1:0])
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extractor: picks the byte/half/word at the given offset of an
// aligned 8-byte word and sign- or zero-extends it; LD passes through.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = ISA_WIDTH
) (
  input  logic [DATA_LEN-1:0]        i_data,
  input  logic [2:0]                 i_offset,
  input  logic [LSU_FUNCT_WIDTH-1:0] i_funct,
  output logic [DATA_LEN-1:0]        o_result
);

  logic [DATA_LEN-1:0] w_shifted;

  assign w_shifted = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_result = '0;
    case (i_funct)
      LSU_LB:  o_result = {{(DATA_LEN-8){w_shifted[7]}}, w_shifted[7:0]};
      LSU_LH:  o_result = {{(DATA_LEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LSU_LW:  o_result = {{(DATA_LEN-32){w_shifted[31]}}, w_shifted[31:0]};
      LSU_LD:  o_result = w_shifted;
      LSU_LBU: o_result = {{(DATA_LEN-8){1'b0}}, w_shifted[7:0]};
      LSU_LHU: o_result = {{(DATA_LEN-16){1'b0}}, w_shifted[15:0]};
      LSU_LWU: o_result = {{(DATA_LEN-32){1'b0}}, w_shifted[31:0]};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one op, issues one aligned memory
// request, waits for the response and holds the result until writeback takes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = ISA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_LEN-1:0]        addr,
  input  logic [DATA_LEN-1:0]        wdata,
  input  logic [LSU_FUNCT_WIDTH-1:0] lsu_funct,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [DATA_LEN-1:0]        mem_addr,
  output logic                       mem_wen,
  output logic [DATA_LEN-1:0]        mem_wdata,
  output logic [DATA_LEN/8-1:0]      mem_wmask,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_LEN-1:0]        mem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_LEN-1:0]        rdata,
  output logic                       err
);

  localparam int MASK_W = DATA_LEN / 8;

  lsu_state_e                 r_state;
  lsu_state_e                 w_next_state;
  logic [DATA_LEN-1:0]        r_addr;
  logic [DATA_LEN-1:0]        r_wdata;
  logic [LSU_FUNCT_WIDTH-1:0] r_funct;
  logic [DATA_LEN-1:0]        r_rdata;
  logic                       r_err;
  logic                       w_in_err;
  logic                       w_accept;
  logic [DATA_LEN-1:0]        w_load_data;
  logic [MASK_W-1:0]          w_mask_base;

  assign w_in_err = !lsu_funct_legal(lsu_funct) || lsu_misaligned(lsu_funct, addr[2:0]);
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)      w_next_state = w_in_err ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_req_ready) w_next_state = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) w_next_state = ST_DONE;
      ST_DONE: if (out_ready)     w_next_state = ST_IDLE;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  lsu_load_align #(
    .DATA_LEN(DATA_LEN)
  ) u_load_align (
    .i_data  (mem_rsp_data),
    .i_offset(r_addr[2:0]),
    .i_funct (r_funct),
    .o_result(w_load_data)
  );

  // Result is cleared on accept so stores and faulting ops report rdata=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_funct <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_funct <= lsu_funct;
        r_rdata <= '0;
        r_err   <= w_in_err;
      end else if (r_state == ST_WAIT && mem_rsp_valid && !r_funct[3]) begin
        r_rdata <= w_load_data;
      end else if (r_state == ST_DONE && out_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  always_comb begin
    w_mask_base = '0;
    case (r_funct[1:0])
      2'd0:    w_mask_base = MASK_W'(8'h01);
      2'd1:    w_mask_base = MASK_W'(8'h03);
      2'd2:    w_mask_base = MASK_W'(8'h0F);
      default: w_mask_base = MASK_W'(8'hFF);
    endcase
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_addr      = {r_addr[DATA_LEN-1:3], 3'b000};
  assign mem_wen       = r_funct[3];
  assign mem_wdata     = r_wdata << {r_addr[2:0], 3'b000};
  assign mem_wmask     = r_funct[3] ? (w_mask_base << r_addr[2:0]) : '0;
  assign out_valid     = (r_state == ST_DONE);
  assign rdata         = r_rdata;
  assign err           = r_err;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, faults, stalls, reset abandon, back-to-back ops.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  lsu_funct;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.DATA_LEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .addr         (addr),
    .wdata        (wdata),
    .lsu_funct    (lsu_funct),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rdata        (rdata),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] d);
    in_valid  = 1'b1;
    lsu_funct = f;
    addr      = a;
    wdata     = d;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_no_early_req"}, mem_req_valid, 0);
    step();
    in_valid  = 1'b0;
    lsu_funct = 4'hF;
    addr      = 64'hDEAD_BEEF_DEAD_BEEF;
    wdata     = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic mem_xfer(input logic [63:0] rsp);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp_rdata, input logic exp_err);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy"}, in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_drop"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; addr = '0; wdata = '0; lsu_funct = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wmask", mem_wmask, 0);
    #20;
    rst = 1'b1;
    step();

    // LW with sign extension, minimum latency
    accept("lw", 4'd2, 64'h8000_0004, 64'h0);
    check("lw_req_valid", mem_req_valid, 1);
    check("lw_mem_addr", mem_addr, 64'h8000_0000);
    check("lw_wen", mem_wen, 0);
    check("lw_wmask", mem_wmask, 0);
    check("lw_no_out", out_valid, 0);
    mem_xfer(64'h8765_4321_0000_0000);
    finish_op("lw", 64'hFFFF_FFFF_8765_4321, 1'b0);

    // SB to byte lane 3
    accept("sb", 4'd8, 64'h8000_0003, 64'hAB);
    check("sb_mem_addr", mem_addr, 64'h8000_0000);
    check("sb_wmask", mem_wmask, 64'h08);
    check("sb_wdata", mem_wdata, 64'hAB00_0000);
    check("sb_wen", mem_wen, 1);
    mem_xfer(64'h1234);
    finish_op("sb", 64'h0, 1'b0);

    // SW to upper word
    accept("sw", 4'd10, 64'h4, 64'h1122_3344_5566_7788);
    check("sw_wmask", mem_wmask, 64'hF0);
    check("sw_wdata", mem_wdata, 64'h5566_7788_0000_0000);
    mem_xfer(64'h0);
    finish_op("sw", 64'h0, 1'b0);

    // Faulting ops: DONE one cycle after accept, no memory request
    accept("lh_mis", 4'd1, 64'h8000_0001, 64'h0);
    check("lh_mis_no_req", mem_req_valid, 0);
    finish_op("lh_mis", 64'h0, 1'b1);
    accept("ill7", 4'd7, 64'h0, 64'h0);
    check("ill7_no_req", mem_req_valid, 0);
    finish_op("ill7", 64'h0, 1'b1);
    accept("sd_mis", 4'd11, 64'h4, 64'h55);
    check("sd_mis_no_req", mem_req_valid, 0);
    finish_op("sd_mis", 64'h0, 1'b1);

    // LD with request and writeback stalls; stray response in REQ is ignored
    accept("ld", 4'd3, 64'h1000, 64'h0);
    for (int i = 0; i < 3; i++) begin
      check("ld_stall_req_valid", mem_req_valid, 1);
      check("ld_stall_addr", mem_addr, 64'h1000);
      check("ld_stall_wen", mem_wen, 0);
      check("ld_stall_in_ready", in_ready, 0);
      mem_rsp_valid = (i == 1);
      mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      step();
      mem_rsp_valid = 1'b0;
    end
    check("ld_still_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ld_wait_no_out", out_valid, 0);
      check("ld_wait_no_req", mem_req_valid, 0);
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0123_4567_89AB_CDEF;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
    in_valid  = 1'b1;
    lsu_funct = 4'd0;
    addr      = 64'h0;
    for (int i = 0; i < 2; i++) begin
      check("ld_hold_valid", out_valid, 1);
      check("ld_hold_rdata", rdata, 64'h0123_4567_89AB_CDEF);
      check("ld_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("ld_done_idle", in_ready, 1);
    check("ld_no_accept_in_done", mem_req_valid, 0);
    step();
    check("ld_still_idle", mem_req_valid, 0);
    check("ld_idle2", in_ready, 1);

    // Reset while waiting for a response abandons the op
    accept("rstw", 4'd2, 64'h0, 64'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    #2;
    check("rstw_in_ready_async", in_ready, 1);
    check("rstw_req_valid", mem_req_valid, 0);
    #2;
    rst = 1'b1;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_out", out_valid, 0);
      check("rstw_idle", in_ready, 1);
      step();
    end

    // Back-to-back LBU / LB at offset 7
    accept("lbu", 4'd4, 64'h7, 64'h0);
    mem_xfer(64'h8000_0000_0000_0000);
    finish_op("lbu", 64'h80, 1'b0);
    accept("lb", 4'd0, 64'h7, 64'h0);
    mem_xfer(64'h8000_0000_0000_0000);
    finish_op("lb", 64'hFFFF_FFFF_FFFF_FF80, 1'b0);

    // Half-word zero extension at offset 2
    accept("lhu", 4'd5, 64'h2, 64'h0);
    mem_xfer(64'h0000_0000_F00D_0000);
    finish_op("lhu", 64'hF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
